// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed driver for an 8-digit common-anode 7-segment display.
// A prescaler divides clk_i into digit slots. A digit index walks 0..7, and a
// shadow copy of the per-digit segment patterns is taken once per frame, so a
// frame is never torn.
// Compile-time option: define SEG_SCAN_BLANK_EN to blank both anodes and
// segments for the first BLANK_CYCLES cycles of every slot (anti-ghosting).
// Without it, BLANK_CYCLES has no effect.

module seg_scan #(
  parameter int unsigned DIV_MAX      = 50000,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [7:0] segs_i [7:0],
  output logic [7:0] an_o,
  output logic [7:0] seg_o,
  output logic       frame_done_o
);

  localparam int unsigned   CW       = $clog2(DIV_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_MAX - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

`ifdef SEG_SCAN_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  // Active-low one-cold anode pattern for a digit index.
  function automatic logic [7:0] anode_decode(input logic [2:0] digit);
    logic [7:0] pat;
    case (digit)
      3'd0:    pat = 8'hFE;
      3'd1:    pat = 8'hFD;
      3'd2:    pat = 8'hFB;
      3'd3:    pat = 8'hF7;
      3'd4:    pat = 8'hEF;
      3'd5:    pat = 8'hDF;
      3'd6:    pat = 8'hBF;
      3'd7:    pat = 8'h7F;
      default: pat = 8'hFF;
    endcase
    return pat;
  endfunction

  // True while the slot is still inside its dead-time window.
  function automatic logic in_blank(input logic [CW-1:0] cnt);
    logic [31:0] cnt_ext;
    logic        blank;
    cnt_ext = 32'(cnt);
    if (BLANK_EN) begin
      blank = (cnt_ext < BLANK_CYCLES);
    end else begin
      blank = 1'b0;
    end
    return blank;
  endfunction

  // State registers
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [2:0]    idx_q,    idx_d;
  logic [7:0]    shadow_q [7:0];
  logic [7:0]    shadow_d [7:0];
  logic          pend_q,   pend_d;   // snapshot owed after reset release
  logic [7:0]    an_q,     an_d;
  logic [7:0]    seg_q,    seg_d;
  logic          frame_q,  frame_d;

  // Combinational helpers
  logic          slot_wrap_s;
  logic          frame_wrap_s;
  logic          load_s;

  // Next-state and output decode; outputs are computed from the post-edge state.
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    pend_d       = pend_q;
    an_d         = 8'hFF;
    seg_d        = 8'hFF;
    frame_d      = 1'b0;
    slot_wrap_s  = 1'b0;
    frame_wrap_s = 1'b0;
    load_s       = 1'b0;

    if (en_i) begin
      slot_wrap_s  = (cnt_q == CNT_LAST);
      frame_wrap_s = slot_wrap_s && (idx_q == 3'd7);
      load_s       = frame_wrap_s || pend_q;

      if (slot_wrap_s) begin
        cnt_d = CNT_ZERO;
        idx_d = idx_q + 3'd1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
        idx_d = idx_q;
      end

      // Snapshot takes the value present at this very edge.
      if (load_s) begin
        for (int k = 0; k < 8; k++) begin
          shadow_d[k] = segs_i[k];
        end
      end else begin
        shadow_d = shadow_q;
      end

      pend_d  = 1'b0;
      frame_d = frame_wrap_s;

      if (in_blank(cnt_d)) begin
        an_d  = 8'hFF;
        seg_d = 8'hFF;
      end else begin
        an_d  = anode_decode(idx_d);
        seg_d = shadow_d[idx_d];
      end
    end else begin
      // Disabled: scan frozen, display dark, no pulse.
      an_d    = 8'hFF;
      seg_d   = 8'hFF;
      frame_d = 1'b0;
    end
  end

  // State and output registers; reset overrides every other update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= CNT_ZERO;
      idx_q   <= 3'd0;
      pend_q  <= 1'b1;
      an_q    <= 8'hFF;
      seg_q   <= 8'hFF;
      frame_q <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        shadow_q[k] <= 8'hFF;
      end
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
      for (int k = 0; k < 8; k++) begin
        shadow_q[k] <= shadow_d[k];
      end
    end
  end

  assign an_o         = an_q;
  assign seg_o        = seg_q;
  assign frame_done_o = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan with DIV_MAX=4, BLANK_CYCLES=1.
// The reference model tracks a single frame position 0..31 and a snapshot
// array. Expected outputs are derived from that position arithmetically.

module tb_seg_scan;

  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = 8 * DIV;

`ifdef SEG_SCAN_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] segs [7:0];
  logic [7:0] an;
  logic [7:0] seg;
  logic       fd;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         pos;
  logic       pend;
  logic [7:0] snap [8];
  logic [7:0] exp_an;
  logic [7:0] exp_seg;
  logic       exp_fd;
  int         pulses;

  always #5 clk = ~clk;

  seg_scan #(.DIV_MAX(DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .segs_i       (segs),
    .an_o         (an),
    .seg_o        (seg),
    .frame_done_o (fd)
  );

  task automatic model_edge();
    logic [2:0] d;
    if (rst) begin
      pos  = 0;
      pend = 1'b1;
      for (int k = 0; k < 8; k++) snap[k] = 8'hFF;
      exp_an  = 8'hFF;
      exp_seg = 8'hFF;
      exp_fd  = 1'b0;
    end else if (!en) begin
      exp_an  = 8'hFF;
      exp_seg = 8'hFF;
      exp_fd  = 1'b0;
    end else begin
      exp_fd = (pos == FRAME - 1);
      if (exp_fd || pend) begin
        for (int k = 0; k < 8; k++) snap[k] = segs[k];
      end
      pend = 1'b0;
      pos  = (pos + 1) % FRAME;
      d    = 3'(pos / DIV);
      if (BLANK_ON && ((pos % DIV) < BLANK)) begin
        exp_an  = 8'hFF;
        exp_seg = 8'hFF;
      end else begin
        exp_an  = ~(8'h01 << d);
        exp_seg = snap[d];
      end
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h pos=%0d", tag, obs, expv, pos);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b pos=%0d", tag, obs, expv, pos);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (fd === 1'b1) pulses++;
    chk8("an", an, exp_an);
    chk8("seg", seg, exp_seg);
    chk1("frame_done", fd, exp_fd);
  endtask

  task automatic run_to(input int target);
    for (int n = 0; n < 2 * FRAME; n++) begin
      if (pos == target) break;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    for (int k = 0; k < 8; k++) segs[k] = 8'h00;

    // reset state
    tick();
    tick();
    chk8("rst_an", an, 8'hFF);
    chk8("rst_seg", seg, 8'hFF);
    chk1("rst_fd", fd, 1'b0);

    // first edge after release snapshots segs_i
    for (int k = 0; k < 8; k++) segs[k] = 8'h10 + 8'(k);
    rst = 1'b0;
    en  = 1'b1;
    tick();
    chk8("first_an", an, 8'hFE);
    chk8("first_seg", seg, 8'h10);

    // free run: exactly two pulses in 64 enabled cycles
    pulses = 0;
    for (int i = 0; i < 2 * FRAME; i++) tick();
    checks++;
    assert (pulses == 2) else begin
      errors++;
      $error("FAIL pulse_count observed=%0d expected=%0d", pulses, 2);
    end

    // no tearing: change digit 3 while digit 1 is shown
    run_to(1 * DIV);
    segs[3] = 8'h00;
    run_to(3 * DIV + 2);
    chk8("torn_an", an, 8'hF7);
    chk8("torn_seg", seg, 8'h13);
    tick();
    run_to(3 * DIV + 2);
    chk8("next_frame_seg", seg, 8'h00);

    // freeze at idx=2, cnt=1 for 5 cycles
    run_to(2 * DIV + 1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk8("frozen_an", an, 8'hFF);
    chk1("frozen_fd", fd, 1'b0);
    en = 1'b1;
    tick();
    chk8("resume_an", an, 8'hFB);
    chk8("resume_seg", seg, 8'h12);

    // segs_i change on the very snapshot edge is captured
    run_to(FRAME - 1);
    segs[0] = 8'hA5;
    tick();
    chk1("wrap_fd", fd, 1'b1);
    chk8("wrap_seg", seg, 8'hA5);

    // randomized enable, pattern updates and occasional reset
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0) segs[$urandom_range(0, 7)] = 8'($urandom);
      tick();
    end
    rst = 1'b0;
    en  = 1'b1;
    tick();

    // reset mid-frame at idx=6
    run_to(6 * DIV + 1);
    rst = 1'b1;
    tick();
    chk8("midrst_an", an, 8'hFF);
    chk8("midrst_seg", seg, 8'hFF);
    chk1("midrst_fd", fd, 1'b0);
    segs[0] = 8'h5A;
    rst = 1'b0;
    tick();
    chk8("restart_an", an, 8'hFE);
    chk8("restart_seg", seg, 8'h5A);
    for (int i = 0; i < FRAME + 4; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
